// File: rtl/lcd_request_arbiter_pkg.sv
// Shared definitions for the LCD request arbiter.
//   - State encoding for the IDLE -> GRANT -> HOLD controller.
//   - Default payload width and abort-counter width.
package lcd_request_arbiter_pkg;

  localparam logic [1:0] IDLE_ENC  = 2'b00;
  localparam logic [1:0] GRANT_ENC = 2'b01;
  localparam logic [1:0] HOLD_ENC  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = IDLE_ENC,
    GRANT = GRANT_ENC,
    HOLD  = HOLD_ENC
  } state_t;

  localparam int DEFAULT_DW = 16;
  localparam int DROP_W     = 4;

endpackage

// File: rtl/lcd_request_arbiter_watchdog.sv
// lcd_ack_watchdog: counts cycles spent waiting for the LCD writer.
// Ports:
//   clk    in  clock, rising edge
//   rst    in  synchronous active-high reset
//   clr    in  restart the count (asserted on the grant cycle)
//   en     in  count this cycle (controller is in GRANT)
//   expire out combinational; high while enabled and count == TIMEOUT-1
module lcd_ack_watchdog #(
  parameter int TIMEOUT = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      // Holding at LAST keeps the counter from ever wrapping.
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/lcd_request_arbiter.sv
// lcd_request_arbiter: shares one LCD writer between the reaction timer
// (requester 0) and the score/statistics block (requester 1).
// Round-robin on simultaneous requests, payload latched at grant, one
// transaction at a time, watchdog abort if the LCD never acknowledges.
// Ports:
//   Clk, Rst            clock / synchronous active-high reset
//   Req0/Data0/Ack0     requester 0 level request, payload, done pulse
//   Req1/Data1/Ack1     requester 1 level request, payload, done pulse
//   LCDUpdate           high for the whole granted transaction
//   LCDData / LCDSrc    latched winner payload and index
//   LCDAck              LCD writer done (only honoured in GRANT)
//   Busy                controller not idle
//   TimeoutErr          sticky abort flag
//   DropCount           saturating abort count
module lcd_request_arbiter
  import lcd_request_arbiter_pkg::*;
#(
  parameter int DW      = DEFAULT_DW,
  parameter int TIMEOUT = 5000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req0,
  input  logic [DW-1:0]     Data0,
  output logic              Ack0,
  input  logic              Req1,
  input  logic [DW-1:0]     Data1,
  output logic              Ack1,
  output logic              LCDUpdate,
  output logic [DW-1:0]     LCDData,
  output logic              LCDSrc,
  input  logic              LCDAck,
  output logic              Busy,
  output logic              TimeoutErr,
  output logic [DROP_W-1:0] DropCount
);

  state_t state;
  logic   ptr;
  logic   win;
  logic   grant_now;
  logic   wd_expire;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + DROP_W'(1);
  endfunction

  // Single request wins outright; a tie goes to the round-robin pointer.
  always_comb begin
    win = (Req0 && Req1) ? ptr : Req1;
  end

  assign grant_now = (state == IDLE) && (Req0 || Req1);

  lcd_ack_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (Clk),
    .rst    (Rst),
    .clr    (grant_now),
    .en     (state == GRANT),
    .expire (wd_expire)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      LCDUpdate  <= 1'b0;
      LCDData    <= '0;
      LCDSrc     <= 1'b0;
      Ack0       <= 1'b0;
      Ack1       <= 1'b0;
      Busy       <= 1'b0;
      TimeoutErr <= 1'b0;
      DropCount  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_now) begin
            LCDData   <= win ? Data1 : Data0;
            LCDSrc    <= win;
            LCDUpdate <= 1'b1;
            Busy      <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          // An ack arriving on the expiry cycle counts as a normal finish.
          if (LCDAck || wd_expire) begin
            LCDUpdate <= 1'b0;
            if (LCDSrc) Ack1 <= 1'b1;
            else        Ack0 <= 1'b1;
            ptr   <= ~LCDSrc;
            state <= HOLD;
            if (!LCDAck) begin
              TimeoutErr <= 1'b1;
              DropCount  <= sat_inc(DropCount);
            end
          end
        end
        HOLD: begin
          // Gives the requester one cycle to drop Req after its Ack.
          Ack0  <= 1'b0;
          Ack1  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_request_arbiter.sv
// Testbench for lcd_request_arbiter (TIMEOUT = 8).
// Stimulus pushes the expected transaction record; a monitor pops one on
// every Ack pulse and checks source, payload, LCDUpdate length and abort.
module tb_lcd_request_arbiter;

  localparam int DW = 16;
  localparam int TO = 8;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          Req0 = 1'b0, Req1 = 1'b0;
  logic [DW-1:0] Data0 = '0, Data1 = '0;
  logic          Ack0, Ack1;
  logic          LCDUpdate;
  logic [DW-1:0] LCDData;
  logic          LCDSrc;
  logic          LCDAck = 1'b0;
  logic          Busy;
  logic          TimeoutErr;
  logic [3:0]    DropCount;

  lcd_request_arbiter #(.DW(DW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req0(Req0), .Data0(Data0), .Ack0(Ack0),
    .Req1(Req1), .Data1(Data1), .Ack1(Ack1),
    .LCDUpdate(LCDUpdate), .LCDData(LCDData), .LCDSrc(LCDSrc),
    .LCDAck(LCDAck), .Busy(Busy), .TimeoutErr(TimeoutErr),
    .DropCount(DropCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic          src;
    logic [DW-1:0] data;
    int            len;
    logic          abort;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   ack_after = 0;   // LCD acks after this many LCDUpdate cycles; 0 = never
  int   rem0 = 0, rem1 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push(input logic src, input logic [DW-1:0] data, input int len,
                      input logic abort);
    exp_t e;
    e.src = src; e.data = data; e.len = len; e.abort = abort;
    sbq.push_back(e);
  endtask

  // LCD writer model
  initial begin : lcd_model
    int hi_cnt;
    hi_cnt = 0;
    forever begin
      @(negedge Clk);
      LCDAck = 1'b0;
      if (LCDUpdate) begin
        hi_cnt++;
        if (ack_after != 0 && hi_cnt == ack_after) LCDAck = 1'b1;
      end else begin
        hi_cnt = 0;
      end
    end
  end

  // Requesters drop Req after their last expected Ack
  initial begin : req_model
    forever begin
      @(negedge Clk);
      if (Ack0 && rem0 > 0) begin
        rem0--;
        if (rem0 == 0) Req0 = 1'b0;
      end
      if (Ack1 && rem1 > 0) begin
        rem1--;
        if (rem1 == 0) Req1 = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin : monitor
    int   len;
    exp_t e;
    len = 0;
    forever begin
      @(negedge Clk);
      if (Ack0 || Ack1) begin
        chk("ack_overlap", {31'd0, Ack0 && Ack1}, 32'd0);
        if (sbq.size() == 0) begin
          chk("unexpected_ack", {30'd0, Ack1, Ack0}, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("ack_src", {31'd0, Ack1}, {31'd0, e.src});
          chk("lcd_src", {31'd0, LCDSrc}, {31'd0, e.src});
          chk("lcd_data", {16'd0, LCDData}, {16'd0, e.data});
          chk("upd_len", len, e.len);
          if (e.abort) chk("timeout_err", {31'd0, TimeoutErr}, 32'd1);
        end
        len = 0;
      end else if (LCDUpdate) begin
        len++;
      end else begin
        len = 0;
      end
    end
  end

  task automatic wait_idle(input string nm, input int maxc);
    int n;
    n = 0;
    while ((Busy || Req0 || Req1 || sbq.size() != 0) && n < maxc) begin
      @(negedge Clk);
      n++;
    end
    chk(nm, {31'd0, n < maxc}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_upd"},  {31'd0, LCDUpdate}, 32'd0);
    chk({nm, "_data"}, {16'd0, LCDData}, 32'd0);
    chk({nm, "_src"},  {31'd0, LCDSrc}, 32'd0);
    chk({nm, "_acks"}, {30'd0, Ack1, Ack0}, 32'd0);
    chk({nm, "_busy"}, {31'd0, Busy}, 32'd0);
    chk({nm, "_terr"}, {31'd0, TimeoutErr}, 32'd0);
    chk({nm, "_drop"}, {28'd0, DropCount}, 32'd0);
  endtask

  initial begin : stim
    // Reset state
    do_reset();
    chk_all_zero("rst");

    // Single request, ack after 5 cycles; data change during GRANT ignored
    ack_after = 5;
    rem0 = 1; Data0 = 16'h04B0; Req0 = 1'b1;
    push(1'b0, 16'h04B0, 5, 1'b0);
    @(negedge Clk);
    chk("latency_upd", {31'd0, LCDUpdate}, 32'd1);
    chk("latency_busy", {31'd0, Busy}, 32'd1);
    Data0 = 16'hFFFF;
    wait_idle("idle_single", 40);
    chk("single_terr", {31'd0, TimeoutErr}, 32'd0);

    // Simultaneous requests after reset: 0 first, then 1
    do_reset();
    ack_after = 3;
    rem0 = 1; rem1 = 1;
    Data0 = 16'h0111; Data1 = 16'h8222;
    Req0 = 1'b1; Req1 = 1'b1;
    push(1'b0, 16'h0111, 3, 1'b0);
    push(1'b1, 16'h8222, 3, 1'b0);
    wait_idle("idle_both", 60);

    // Both held for four transactions: 0,1,0,1
    ack_after = 2;
    rem0 = 2; rem1 = 2;
    Data0 = 16'h0A0A; Data1 = 16'h0B0B;
    Req0 = 1'b1; Req1 = 1'b1;
    for (int i = 0; i < 4; i++) push(i[0], i[0] ? 16'h0B0B : 16'h0A0A, 2, 1'b0);
    wait_idle("idle_rr", 100);

    // Timeout: no LCDAck -> 8 cycles of LCDUpdate, abort
    ack_after = 0;
    rem0 = 1; Data0 = 16'h0300; Req0 = 1'b1;
    push(1'b0, 16'h0300, TO, 1'b1);
    wait_idle("idle_to1", 60);
    chk("to1_terr", {31'd0, TimeoutErr}, 32'd1);
    chk("to1_drop", {28'd0, DropCount}, 32'd1);

    // 15 more aborts: DropCount saturates at 15
    for (int i = 0; i < 15; i++) begin
      rem1 = 1; Data1 = 16'h1000 + 16'(i); Req1 = 1'b1;
      push(1'b1, 16'h1000 + 16'(i), TO, 1'b1);
      wait_idle("idle_to_loop", 60);
    end
    chk("sat_drop", {28'd0, DropCount}, 32'd15);
    chk("sat_terr", {31'd0, TimeoutErr}, 32'd1);

    // Ack on the expiry cycle wins: no error
    do_reset();
    chk("rst2_terr", {31'd0, TimeoutErr}, 32'd0);
    ack_after = TO;
    rem0 = 1; Data0 = 16'h0777; Req0 = 1'b1;
    push(1'b0, 16'h0777, TO, 1'b0);
    wait_idle("idle_edge", 60);
    chk("edge_terr", {31'd0, TimeoutErr}, 32'd0);
    chk("edge_drop", {28'd0, DropCount}, 32'd0);

    // Reset mid-GRANT (pointer is 1 here); killed grant produces no Ack
    ack_after = 0;
    rem0 = 1; Data0 = 16'h0999; Req0 = 1'b1;
    repeat (3) @(negedge Clk);
    chk("midrst_upd_before", {31'd0, LCDUpdate}, 32'd1);
    Rst = 1'b1; Req0 = 1'b0; rem0 = 0;
    @(negedge Clk);
    Rst = 1'b0;
    chk_all_zero("midrst");
    repeat (12) @(negedge Clk);
    chk("midrst_no_ack_q", sbq.size(), 0);

    // Pointer back to 0: tie goes to requester 0
    ack_after = 3;
    rem0 = 1; rem1 = 1;
    Data0 = 16'h0044; Data1 = 16'h0055;
    Req0 = 1'b1; Req1 = 1'b1;
    push(1'b0, 16'h0044, 3, 1'b0);
    push(1'b1, 16'h0055, 3, 1'b0);
    wait_idle("idle_post_rst_tie", 60);

    // Req1 then Req0 after reset
    rem1 = 1; Data1 = 16'h0123; Req1 = 1'b1;
    push(1'b1, 16'h0123, 3, 1'b0);
    wait_idle("idle_post_rst1", 40);
    rem0 = 1; Data0 = 16'h0321; Req0 = 1'b1;
    push(1'b0, 16'h0321, 3, 1'b0);
    wait_idle("idle_post_rst0", 40);
    chk("final_terr", {31'd0, TimeoutErr}, 32'd0);
    chk("final_drop", {28'd0, DropCount}, 32'd0);
    chk("final_busy", {31'd0, Busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard against a hung run
  initial begin : guard
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
